multi_pulse_gen: RTL and testbench

Multi-channel, runtime-programmable successor to the single fixed-rate capture-strobe generator. It provides NUM_CH independent strobe channels. Each channel has its own period, and each can run continuously or emit a finite burst. Period changes are glitch-free and take effect only at a period boundary. It sits beside the I2C/sampling logic and supplies per-channel `capture` strobes. Out of reset every channel behaves exactly like the original fixed generator at DEFAULT_PULSE_FREQ.

---
 rtl/multi_pulse_gen.sv | 123 ++++++++++++
 tb/tb_multi_pulse_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_gen.sv
// NUM_CH independent capture-strobe channels, each with a runtime period and an optional finite burst.
// Latency: capture is combinational from registers. A config takes effect next cycle if the channel is idle, or at its next capture if running.
// Backpressure: cfg_ready drops per channel while an update is pending. Optional sync_in port with MULTI_PULSE_GEN_SYNC_EN.
module multi_pulse_gen #(
    parameter int FREQ_HZ            = 100000000,
    parameter int DEFAULT_PULSE_FREQ = 200000,
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 32,
    parameter int BURST_W            = 16
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic                                               cfg_valid,
    output logic                                               cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]                                   cfg_period,
    input  logic [BURST_W-1:0]                                 cfg_burst,
`ifdef MULTI_PULSE_GEN_SYNC_EN
    input  logic                                               sync_in,
`endif
    output logic [NUM_CH-1:0]                                  capture,
    output logic [NUM_CH-1:0]                                  busy,
    output logic [NUM_CH-1:0]                                  done
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RST_DIV = FREQ_HZ / DEFAULT_PULSE_FREQ;
    localparam logic [CNT_W-1:0] RST_PERIOD = (RST_DIV < 2) ? CNT_W'(1) : CNT_W'(RST_DIV);

    logic              sync_w;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] pend_v;
    logic              xfer;
    logic [CNT_W-1:0]  cfg_period_c;

`ifdef MULTI_PULSE_GEN_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // Periods below 1 are meaningless; 0 and 1 both mean "strobe every cycle".
    assign cfg_period_c = (cfg_period < CNT_W'(2)) ? CNT_W'(1) : cfg_period;

    always_comb begin
        cfg_ready = 1'b1;
        sel       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend_v[i];
                sel[i]    = 1'b1;
            end
        end
    end

    assign xfer = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0]   counter;
        logic [CNT_W-1:0]   period_act;
        logic [CNT_W-1:0]   period_shd;
        logic [BURST_W-1:0] burst_rem;
        logic [BURST_W-1:0] burst_shd;
        logic               running;
        logic               pending;
        logic               done_q;
        logic               cap;
        logic               apply;

        assign cap   = running && (counter == period_act - CNT_W'(1));
        assign apply = pending && (!running || cap || sync_w);

        always_ff @(posedge clk) begin
            if (!resetn) begin
                counter    <= '0;
                period_act <= RST_PERIOD;
                period_shd <= RST_PERIOD;
                burst_rem  <= '0;
                burst_shd  <= '0;
                running    <= 1'b1;
                pending    <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                done_q <= 1'b0;
                // An apply on a capture cycle supersedes the old burst's decrement and done.
                if (apply) begin
                    period_act <= period_shd;
                    burst_rem  <= burst_shd;
                    counter    <= '0;
                    running    <= 1'b1;
                    pending    <= 1'b0;
                end else begin
                    if (cap) begin
                        counter <= '0;
                        if (burst_rem != '0) begin
                            burst_rem <= burst_rem - BURST_W'(1);
                            if (burst_rem == BURST_W'(1)) begin
                                running <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end else if (running) begin
                        counter <= counter + CNT_W'(1);
                    end
                    if (sync_w && running) begin
                        counter <= '0;
                    end
                end
                if (xfer && sel[g]) begin
                    period_shd <= cfg_period_c;
                    burst_shd  <= cfg_burst;
                    pending    <= 1'b1;
                end
            end
        end

        assign capture[g] = cap;
        assign busy[g]    = running;
        assign done[g]    = done_q;
        assign pend_v[g]  = pending;
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Randomized bench for multi_pulse_gen: a time-based channel model predicts every strobe, done and ready.
// Directed phases pin the model with hand-computed strobe times, burst spacing and reset behaviour.
module tb_multi_pulse_gen;

    localparam int NCH = 4;
    localparam int P0  = 500;

    logic        clk;
    logic        resetn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_period;
    logic [15:0] cfg_burst;
    logic [3:0]  capture;
    logic [3:0]  busy;
    logic [3:0]  done;

    int checks   = 0;
    int failures = 0;

    multi_pulse_gen #(
        .FREQ_HZ(100000000), .DEFAULT_PULSE_FREQ(200000),
        .NUM_CH(NCH), .CNT_W(32), .BURST_W(16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_burst(cfg_burst),
        .capture(capture), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is described by the absolute cycle of its next strobe.
    longint cyc = 0;
    bit     chk_en = 0;
    longint next_cap [NCH];
    longint per      [NCH];
    longint rem      [NCH];
    longint shd_p    [NCH];
    longint shd_b    [NCH];
    bit     run      [NCH];
    bit     pend     [NCH];
    bit     dn       [NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [3:0] ecap, ebusy, edone;
    logic       erdy, mxfer, mcap;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) begin
                ecap[i]  = run[i] && (cyc == next_cap[i]);
                ebusy[i] = run[i];
                edone[i] = dn[i];
            end
            erdy = !pend[cfg_ch];
            chk("capture", 32'(capture), 32'(ecap));
            chk("busy", 32'(busy), 32'(ebusy));
            chk("done", 32'(done), 32'(edone));
            chk("cfg_ready", 32'(cfg_ready), 32'(erdy));
        end
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                next_cap[i] = cyc + P0;
                per[i] = P0; shd_p[i] = P0;
                rem[i] = 0;  shd_b[i] = 0;
                run[i] = 1;  pend[i] = 0; dn[i] = 0;
            end
            chk_en = 1;
        end else if (chk_en) begin
            mxfer = cfg_valid && !pend[cfg_ch];
            for (int i = 0; i < NCH; i++) begin
                mcap  = run[i] && (cyc == next_cap[i]);
                dn[i] = 0;
                if (pend[i] && (!run[i] || mcap)) begin
                    per[i] = shd_p[i]; rem[i] = shd_b[i];
                    run[i] = 1; pend[i] = 0;
                    next_cap[i] = cyc + per[i];
                end else if (mcap) begin
                    next_cap[i] = cyc + per[i];
                    if (rem[i] != 0) begin
                        if (rem[i] == 1) begin
                            run[i] = 0; dn[i] = 1;
                        end
                        rem[i]--;
                    end
                end
                if (mxfer && (int'(cfg_ch) == i)) begin
                    shd_p[i] = (cfg_period < 2) ? 1 : longint'(cfg_period);
                    shd_b[i] = longint'(cfg_burst);
                    pend[i]  = 1;
                end
            end
        end
        cyc++;
    end

    task automatic cfg_write(input int ch, input int p, input int b);
        bit ok;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = 32'(p); cfg_burst = 16'(b);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("cfg_accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_applied(input int ch);
        bit ok;
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_ch = 2'(ch);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1; break; end
        end
        chk("apply_in_time", 32'(ok), 32'd1);
    endtask

    int q_cap [$];
    int q_dn  [$];
    int cnt;
    int first1;

    initial begin
        resetn = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_period = '0; cfg_burst = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset default: period 500 on every channel.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("reset_busy", 32'(busy), 32'hF);
                chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
            end
            if (capture[0]) begin
                q_cap.push_back(c);
                chk("reset_all_capture", 32'(capture), 32'hF);
            end
        end
        chk("reset_cap_count", 32'(q_cap.size()), 32'd4);
        if (q_cap.size() == 4) begin
            chk("cap_t0", 32'(q_cap[0]), 32'd499);
            chk("cap_t1", 32'(q_cap[1]), 32'd999);
            chk("cap_t2", 32'(q_cap[2]), 32'd1499);
            chk("cap_t3", 32'(q_cap[3]), 32'd1999);
        end
        chk("run_busy", 32'(busy), 32'hF);
        chk("run_done", 32'(done), 32'h0);

        // Burst of 3 at period 10 on a running channel.
        cfg_write(1, 10, 3);
        q_cap.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (capture[1]) q_cap.push_back(c);
            if (done[1]) q_dn.push_back(c);
        end
        chk("burst_cap_count", 32'(q_cap.size()), 32'd4);
        chk("burst_done_count", 32'(q_dn.size()), 32'd1);
        if (q_cap.size() == 4 && q_dn.size() == 1) begin
            chk("burst_gap1", 32'(q_cap[1] - q_cap[0]), 32'd10);
            chk("burst_gap2", 32'(q_cap[2] - q_cap[1]), 32'd10);
            chk("burst_gap3", 32'(q_cap[3] - q_cap[2]), 32'd10);
            chk("burst_done_t", 32'(q_dn[0] - q_cap[3]), 32'd1);
        end
        chk("burst_busy1", 32'(busy[1]), 32'd0);

        // Period 0 clamps to 1: strobe every cycle.
        cfg_write(2, 0, 0);
        wait_applied(2);
        repeat (2) @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (capture[2]) cnt++;
        end
        chk("period1_every_cycle", 32'(cnt), 32'd20);

        // Second write while ch0 still pending.
        cfg_write(0, 37, 0);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 32'd50; cfg_burst = 16'd0;
        @(negedge clk);
        chk("pending_ready_ch0", 32'(cfg_ready), 32'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_ch = 2'd3;
        @(negedge clk);
        chk("other_ready_ch3", 32'(cfg_ready), 32'd1);
        cfg_write(0, 50, 0);

        for (int n = 0; n < 40; n++) begin
            cfg_write($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 4));
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end
        repeat (100) @(posedge clk);

        // Reset in the middle of a burst with an update pending.
        cfg_write(1, 9, 5);
        wait_applied(1);
        cfg_write(1, 20, 2);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        cnt = 0; first1 = -1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("rst2_busy", 32'(busy), 32'hF);
                chk("rst2_ready_ch1", 32'(cfg_ready), 32'd1);
            end
            if (done != 4'h0) cnt++;
            if (capture[1] && first1 < 0) first1 = c;
        end
        chk("rst2_no_done", 32'(cnt), 32'd0);
        chk("rst2_first_cap1", 32'(first1), 32'd499);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
